// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared opcodes, channel states and time constants for the countdown timer bank
package timer_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_ADD      = 3'd1,
    CMD_SUB      = 3'd2,
    CMD_START    = 3'd3,
    CMD_PAUSE    = 3'd4,
    CMD_CLEAR    = 3'd5,
    CMD_AUTO_ON  = 3'd6,
    CMD_AUTO_OFF = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int SEC_MAX = 59;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one mm:ss countdown channel: state FSM, count/reload/auto registers
module timer_channel
  import timer_pkg::*;
#(
  parameter int MIN_W    = 6,
  parameter int SEC_W    = 6,
  parameter int MAX_MIN  = 59,
  parameter int STEP_SEC = 30
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     tick,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd,
  output logic [MIN_W+SEC_W-1:0]   count,
  output logic                     running,
  output logic                     time_up,
  output logic                     expire_p
);

  localparam logic [SEC_W:0] STEP_X  = (SEC_W+1)'(STEP_SEC);
  localparam logic [SEC_W:0] SIXTY_X = (SEC_W+1)'(SEC_MAX + 1);

  state_e            state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d, rmin_q, rmin_d;
  logic [SEC_W-1:0]  sec_q, sec_d, rsec_q, rsec_d;
  logic              auto_q, auto_d;
  logic              expire_q, expire_d;

  logic [SEC_W:0]    sec_add, sec_borrow;
  logic [MIN_W:0]    min_inc;
  logic              add_carry, is_zero, can_edit;
  logic [MIN_W-1:0]  add_min, sub_min;
  logic [SEC_W-1:0]  add_sec, sub_sec;
  cmd_e              cmd_op;

  assign cmd_op = cmd_e'(cmd);

  // Saturating add/sub of STEP_SEC, computed unconditionally and selected below.
  always_comb begin
    sec_add    = {1'b0, sec_q} + STEP_X;
    add_carry  = (sec_add >= SIXTY_X);
    min_inc    = {1'b0, min_q} + (MIN_W+1)'(add_carry);
    sec_borrow = {1'b0, sec_q} + SIXTY_X - STEP_X;
    if (min_inc > (MIN_W+1)'(MAX_MIN)) begin
      add_min = MIN_W'(MAX_MIN);
      add_sec = SEC_W'(SEC_MAX);
    end else begin
      add_min = min_inc[MIN_W-1:0];
      add_sec = add_carry ? SEC_W'(sec_add - SIXTY_X) : sec_add[SEC_W-1:0];
    end
    if ({1'b0, sec_q} >= STEP_X) begin
      sub_min = min_q;
      sub_sec = SEC_W'({1'b0, sec_q} - STEP_X);
    end else if (min_q != '0) begin
      sub_min = min_q - MIN_W'(1);
      sub_sec = sec_borrow[SEC_W-1:0];
    end else begin
      sub_min = '0;
      sub_sec = '0;
    end
  end

  assign is_zero  = (min_q == '0) && (sec_q == '0);
  assign can_edit = (state_q == IDLE) || (state_q == PAUSED);

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    rmin_d   = rmin_q;
    rsec_d   = rsec_q;
    auto_d   = auto_q;
    expire_d = 1'b0;
    // Any real command to this channel takes priority; its tick is dropped.
    if (cmd_valid && cmd_op != CMD_NOP) begin
      case (cmd_op)
        CMD_ADD: if (can_edit) begin
          min_d = add_min;
          sec_d = add_sec;
        end
        CMD_SUB: if (can_edit) begin
          min_d = sub_min;
          sec_d = sub_sec;
        end
        CMD_START: begin
          if (can_edit && !is_zero) begin
            state_d = RUN;
            if (state_q == IDLE) begin
              rmin_d = min_q;
              rsec_d = sec_q;
            end
          end else if (state_q == EXPIRED && (rmin_q != '0 || rsec_q != '0)) begin
            state_d = RUN;
            min_d   = rmin_q;
            sec_d   = rsec_q;
          end
        end
        CMD_PAUSE: if (state_q == RUN) state_d = PAUSED;
        CMD_CLEAR: begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
          rmin_d  = '0;
          rsec_d  = '0;
        end
        CMD_AUTO_ON:  auto_d = 1'b1;
        CMD_AUTO_OFF: auto_d = 1'b0;
        default: ;
      endcase
    end else if (tick && state_q == RUN) begin
      if (min_q == '0 && sec_q <= SEC_W'(1)) begin
        expire_d = 1'b1;
        if (auto_q) begin
          min_d = rmin_q;
          sec_d = rsec_q;
        end else begin
          state_d = EXPIRED;
          min_d   = '0;
          sec_d   = '0;
        end
      end else if (sec_q != '0) begin
        sec_d = sec_q - SEC_W'(1);
      end else begin
        min_d = min_q - MIN_W'(1);
        sec_d = SEC_W'(SEC_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      min_q    <= '0;
      sec_q    <= '0;
      rmin_q   <= '0;
      rsec_q   <= '0;
      auto_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      rmin_q   <= rmin_d;
      rsec_q   <= rsec_d;
      auto_q   <= auto_d;
      expire_q <= expire_d;
    end
  end

  assign count    = {min_q, sec_q};
  assign running  = (state_q == RUN);
  assign time_up  = (state_q == EXPIRED);
  assign expire_p = expire_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// rtl/countdown_timer_bank.sv - N_CH countdown channels sharing one command port and seconds tick
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int   N_CH     = 2,
  parameter int   MIN_W    = 6,
  parameter int   SEC_W    = 6,
  parameter int   MAX_MIN  = 59,
  parameter int   STEP_SEC = 30,
  localparam int  CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int  CNT_W    = MIN_W + SEC_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   tick,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [CH_W-1:0]        cmd_ch,
  output logic [N_CH*CNT_W-1:0]  count_out,
  output logic [N_CH-1:0]        running,
  output logic [N_CH-1:0]        time_up,
  output logic [N_CH-1:0]        expire_p
);

  // Out-of-range channel numbers match no instance, so they are dropped here.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_valid;
    assign ch_valid = cmd_valid && (cmd_ch == CH_W'(i));

    timer_channel #(
      .MIN_W    (MIN_W),
      .SEC_W    (SEC_W),
      .MAX_MIN  (MAX_MIN),
      .STEP_SEC (STEP_SEC)
    ) u_ch (
      .clk       (clk),
      .nrst      (nrst),
      .tick      (tick),
      .cmd_valid (ch_valid),
      .cmd       (cmd),
      .count     (count_out[i*CNT_W +: CNT_W]),
      .running   (running[i]),
      .time_up   (time_up[i]),
      .expire_p  (expire_p[i])
    );
  end

endmodule
